// File: rtl/writeback_if.sv
// writeback_if: memory-to-writeback pipeline bus.
//   Carries the memory-stage pipeline register outputs (*_mem) into the
//   writeback stage. It also carries the commit result (rd_wb, rd_address_wb,
//   rd_data_wb) back out, which decode uses for forwarding.
//   master: the memory stage or bench. It drives *_mem and observes the commit.
//   slave : the writeback stage. It consumes *_mem and drives the commit.
// Handshake: there is no ready. valid_mem qualifies the slot, and the slot is
//   consumed on every posedge where valid_mem=1 and the stage is not stalled
//   or in reset. rd_wb is a one-cycle strobe with no backpressure.
interface writeback_if #(
  parameter int WIDTH          = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      valid_mem;
  logic [WIDTH-1:0]          pc_mem;
  logic                      link_mem;
  logic                      load_mem;
  logic [WIDTH-1:0]          read_data_mem;
  logic                      alu_mode_mem;
  logic [WIDTH-1:0]          alu_result_mem;
  logic                      rd_mem;
  logic [REG_ADDR_WIDTH-1:0] rd_address_mem;
  logic                      rd_wb;
  logic [REG_ADDR_WIDTH-1:0] rd_address_wb;
  logic [WIDTH-1:0]          rd_data_wb;

  modport master (
    output valid_mem, pc_mem, link_mem, load_mem, read_data_mem,
           alu_mode_mem, alu_result_mem, rd_mem, rd_address_mem,
    input  rd_wb, rd_address_wb, rd_data_wb
  );

  modport slave (
    input  valid_mem, pc_mem, link_mem, load_mem, read_data_mem,
           alu_mode_mem, alu_result_mem, rd_mem, rd_address_mem,
    output rd_wb, rd_address_wb, rd_data_wb
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: final MIPS R2000 pipeline stage.
//   Selects the writeback value (link address > load data > ALU result) and
//   commits it to the architectural register file. r1..r31 are stored; r0
//   reads as zero. Two combinational read ports serve decode, with
//   write-through bypass. Retire statistics are kept for debug.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   wb (slave)        memory-stage inputs and commit outputs (see writeback_if)
//   i_stall           pipeline hold: no commit, no retire, bypass disabled
//   i_rs_address/o_rs_data, i_rt_address/o_rt_data   decode read ports
//   o_reg_file        register contents, entry i = r(i+1)
//   o_retired_count   retired instruction count (wraps)
//   o_retired_pc      PC of last retired instruction
// There is no FSM in this block. All state is the register file and the two
// retire registers.
module writeback_stage #(
  parameter int WIDTH          = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_COUNT      = 32,
  parameter int LINK_OFFSET    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  writeback_if.slave                         wb,
  input  logic                               i_stall,
  input  logic [REG_ADDR_WIDTH-1:0]          i_rs_address,
  input  logic [REG_ADDR_WIDTH-1:0]          i_rt_address,
  output logic [WIDTH-1:0]                   o_rs_data,
  output logic [WIDTH-1:0]                   o_rt_data,
  output logic [REG_COUNT-2:0][WIDTH-1:0]    o_reg_file,
  output logic [WIDTH-1:0]                   o_retired_count,
  output logic [WIDTH-1:0]                   o_retired_pc
);

  logic [REG_COUNT-2:0][WIDTH-1:0] r_regs;
  logic [WIDTH-1:0]                r_retired_count;
  logic [WIDTH-1:0]                r_retired_pc;

  logic [WIDTH-1:0] w_value;
  logic             w_we;
  logic             w_retire;
  logic             w_unused_alu_mode;

  // alu_mode_mem is informational only. The ALU result is the fallback
  // source whether or not it is set.
  assign w_unused_alu_mode = wb.alu_mode_mem;

  always_comb begin
    if (wb.link_mem)
      w_value = wb.pc_mem + WIDTH'(LINK_OFFSET);
    else if (wb.load_mem)
      w_value = wb.read_data_mem;
    else
      w_value = wb.alu_result_mem;
  end

  assign w_we     = wb.valid_mem & wb.rd_mem & (wb.rd_address_mem != '0)
                  & ~i_stall & ~rst;
  assign w_retire = wb.valid_mem & ~i_stall & ~rst;

  assign wb.rd_wb         = w_we;
  assign wb.rd_address_wb = w_we ? wb.rd_address_mem : '0;
  assign wb.rd_data_wb    = w_we ? w_value : '0;

  // Read ports. Address 0 matches no stored entry and so reads 0. w_we is
  // already false for r0, so the bypass never fires on it either.
  always_comb begin
    o_rs_data = '0;
    o_rt_data = '0;
    for (int i = 0; i < REG_COUNT - 1; i++) begin
      if (i_rs_address == REG_ADDR_WIDTH'(i + 1)) o_rs_data = r_regs[i];
      if (i_rt_address == REG_ADDR_WIDTH'(i + 1)) o_rt_data = r_regs[i];
    end
    if (w_we && (i_rs_address == wb.rd_address_mem)) o_rs_data = w_value;
    if (w_we && (i_rt_address == wb.rd_address_mem)) o_rt_data = w_value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs          <= '0;
      r_retired_count <= '0;
      r_retired_pc    <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT - 1; i++) begin
        if (w_we && (wb.rd_address_mem == REG_ADDR_WIDTH'(i + 1)))
          r_regs[i] <= w_value;
      end
      if (w_retire) begin
        r_retired_count <= r_retired_count + 1'b1;
        r_retired_pc    <= wb.pc_mem;
      end
    end
  end

  assign o_reg_file      = r_regs;
  assign o_retired_count = r_retired_count;
  assign o_retired_pc    = r_retired_pc;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  localparam int W  = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;
  logic stall;
  logic [AW-1:0] rs_address, rt_address;
  logic [W-1:0]  rs_data, rt_data;
  logic [30:0][W-1:0] reg_file;
  logic [W-1:0]  retired_count, retired_pc;

  writeback_if #(.WIDTH(W), .REG_ADDR_WIDTH(AW)) wbif ();

  writeback_stage dut (
    .clk             (clk),
    .rst             (rst),
    .wb              (wbif.slave),
    .i_stall         (stall),
    .i_rs_address    (rs_address),
    .i_rt_address    (rt_address),
    .o_rs_data       (rs_data),
    .o_rt_data       (rt_data),
    .o_reg_file      (reg_file),
    .o_retired_count (retired_count),
    .o_retired_pc    (retired_pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required $finish before 200000");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  logic [AW+W-1:0] exp_q[$];
  logic [W-1:0]    m_regs [31];
  logic [W-1:0]    m_count;
  logic [W-1:0]    m_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops one expected {addr,data} per commit strobe
  always @(negedge clk) begin
    if (wbif.rd_wb === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit: got addr=%0d data=0x%0h expected no commit",
                 wbif.rd_address_wb, wbif.rd_data_wb);
      end else begin
        logic [AW+W-1:0] e;
        e = exp_q.pop_front();
        check("commit", {wbif.rd_address_wb, wbif.rd_data_wb}, e);
      end
    end
  end

  // driver: sets the slot, checks the strobe mid-cycle, updates the model.
  // Returns at the negedge so the caller can probe the read ports before tick().
  task automatic apply(input logic v, input logic [W-1:0] pc, input logic lk, input logic ld,
                       input logic [W-1:0] rdat, input logic am, input logic [W-1:0] alu,
                       input logic rdm, input logic [AW-1:0] addr, input logic st,
                       input logic rs_i, input logic exp_we, input logic [W-1:0] exp_data);
    wbif.valid_mem      = v;
    wbif.pc_mem         = pc;
    wbif.link_mem       = lk;
    wbif.load_mem       = ld;
    wbif.read_data_mem  = rdat;
    wbif.alu_mode_mem   = am;
    wbif.alu_result_mem = alu;
    wbif.rd_mem         = rdm;
    wbif.rd_address_mem = addr;
    stall               = st;
    rst                 = rs_i;
    if (exp_we) exp_q.push_back({addr, exp_data});
    @(negedge clk);
    check("rd_wb", {63'd0, wbif.rd_wb}, {63'd0, exp_we});
    if (!exp_we) begin
      check("rd_address_wb_zero", {59'd0, wbif.rd_address_wb}, 64'd0);
      check("rd_data_wb_zero", {32'd0, wbif.rd_data_wb}, 64'd0);
    end
    if (rs_i) begin
      for (int i = 0; i < 31; i++) m_regs[i] = '0;
      m_count = '0;
      m_pc    = '0;
    end else begin
      if (exp_we) m_regs[addr-1] = exp_data;
      if (v && !st) begin
        m_count = m_count + 1;
        m_pc    = pc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wbif.valid_mem = 1'b0;
    stall          = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 31; i++)
      check({tag, "_reg"}, {32'd0, reg_file[i]}, {32'd0, m_regs[i]});
    check({tag, "_count"}, {32'd0, retired_count}, {32'd0, m_count});
    check({tag, "_pc"}, {32'd0, retired_pc}, {32'd0, m_pc});
  endtask

  initial begin
    logic [W-1:0]  r;
    logic [AW-1:0] a;
    rst = 1'b1;
    stall = 1'b0;
    rs_address = '0;
    rt_address = '0;
    wbif.valid_mem = 1'b0;
    wbif.pc_mem = '0;
    wbif.link_mem = 1'b0;
    wbif.load_mem = 1'b0;
    wbif.read_data_mem = '0;
    wbif.alu_mode_mem = 1'b0;
    wbif.alu_result_mem = '0;
    wbif.rd_mem = 1'b0;
    wbif.rd_address_mem = '0;
    for (int i = 0; i < 31; i++) m_regs[i] = '0;
    m_count = '0;
    m_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // random traffic, then 2 reset cycles with writes pending
    for (int k = 0; k < 5; k++) begin
      r = $urandom;
      a = AW'($urandom_range(1, 31));
      apply(1, 32'h1000 + 32'(k*4), 0, 0, 0, 1, r, 1, a, 0, 0, 1, r);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      r = $urandom;
      a = AW'($urandom_range(1, 31));
      apply(1, 32'h2000, 0, 0, 0, 1, r, 1, a, 0, 1, 0, 0);
      tick();
    end
    check_state("reset");
    check("reset_count_const", {32'd0, retired_count}, 64'd0);

    // ALU write r5
    apply(1, 32'h100, 0, 0, 0, 1, 32'h1234, 1, 5'd5, 0, 0, 1, 32'h1234);
    tick();
    check("alu_r5", {32'd0, reg_file[4]}, 64'h1234);
    check("alu_count", {32'd0, retired_count}, 64'd1);

    // link beats load
    apply(1, 32'h0040_0010, 1, 1, 32'hDEAD_0000, 0, 32'h77, 1, 5'd31, 0, 0, 1, 32'h0040_0018);
    tick();
    check("link_r31", {32'd0, reg_file[30]}, 64'h0040_0018);

    // load beats alu
    apply(1, 32'h108, 0, 1, 32'hFFFF_FF80, 1, 32'h10, 1, 5'd3, 0, 0, 1, 32'hFFFF_FF80);
    tick();
    check("load_r3", {32'd0, reg_file[2]}, 64'hFFFF_FF80);

    // alu_mode=0 still picks ALU result
    apply(1, 32'h10C, 0, 0, 0, 0, 32'h55, 1, 5'd4, 0, 0, 1, 32'h55);
    tick();

    // write to r0: suppressed, counted
    apply(1, 32'h110, 0, 0, 0, 1, 32'h99, 1, 5'd0, 0, 0, 0, 0);
    tick();
    // store-like: rd_mem=0
    apply(1, 32'h114, 0, 0, 0, 1, 32'h66, 0, 5'd6, 0, 0, 0, 0);
    tick();
    // bubble: nothing
    apply(0, 32'h118, 0, 0, 0, 1, 32'h67, 1, 5'd6, 0, 0, 0, 0);
    tick();
    check_state("r0_bubble");
    check("r0_bubble_count", {32'd0, retired_count}, 64'd6);
    check("bubble_pc", {32'd0, retired_pc}, 64'h114);

    // bypass: r7=0x1111 stored, then write 0xCAFE with rs=rt=7
    apply(1, 32'h120, 0, 0, 0, 1, 32'h1111, 1, 5'd7, 0, 0, 1, 32'h1111);
    tick();
    rs_address = 5'd7;
    rt_address = 5'd7;
    apply(1, 32'h124, 0, 0, 0, 1, 32'hCAFE, 1, 5'd7, 0, 0, 1, 32'hCAFE);
    check("bypass_rs", {32'd0, rs_data}, 64'hCAFE);
    check("bypass_rt", {32'd0, rt_data}, 64'hCAFE);
    tick();
    // stall: old value, no commit, no count
    apply(1, 32'h128, 0, 0, 0, 1, 32'hBEEF, 1, 5'd7, 1, 0, 0, 0);
    check("stall_rs", {32'd0, rs_data}, 64'hCAFE);
    check("stall_rt", {32'd0, rt_data}, 64'hCAFE);
    tick();
    check("stall_r7", {32'd0, reg_file[6]}, 64'hCAFE);
    check("stall_count", {32'd0, retired_count}, 64'd8);
    // read r0 and a stored register alongside a bypass on the other port
    rs_address = 5'd0;
    rt_address = 5'd5;
    apply(1, 32'h12C, 0, 0, 0, 1, 32'h4242, 1, 5'd9, 0, 0, 1, 32'h4242);
    check("read_r0", {32'd0, rs_data}, 64'd0);
    check("read_r5", {32'd0, rt_data}, 64'h1234);
    tick();
    check_state("after_bypass");

    // counter wrap
    force dut.r_retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired_count;
    #1;
    check("preload_count", {32'd0, retired_count}, 64'hFFFF_FFFF);
    apply(1, 32'h200, 0, 0, 0, 1, 0, 0, 5'd0, 0, 0, 0, 0);
    tick();
    check("wrap_count", {32'd0, retired_count}, 64'd0);
    check("wrap_pc", {32'd0, retired_pc}, 64'h200);
    m_count = '0;

    // reset with a valid write pending: dropped
    apply(1, 32'h300, 0, 0, 0, 1, 32'h777, 1, 5'd9, 0, 1, 0, 0);
    tick();
    check("rst_mid_r9", {32'd0, reg_file[8]}, 64'd0);
    check_state("rst_mid");

    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
